// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM bank.
package pwm_pkg;
    typedef enum logic {PWM_EDGE = 1'b0, PWM_CENTER = 1'b1} pwm_mode_e;
    localparam int PWM_CNT_W = 16;
endpackage

// File: rtl/pwm_compare_ch.sv
// One PWM channel: double-buffered duty/polarity plus compare and output register.
module pwm_compare_ch
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             apply,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             pol_in,
    output logic             pwm
);
    logic [CNT_W-1:0] duty_sh, duty_act;
    logic             pol_sh, pol_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_sh  <= '0;
            duty_act <= '0;
            pol_sh   <= 1'b0;
            pol_act  <= 1'b0;
            pwm      <= 1'b0;
        end else begin
            if (load) begin
                duty_sh <= duty_in;
                pol_sh  <= pol_in;
            end
            // apply always takes the pre-load shadow
            if (apply) begin
                duty_act <= duty_sh;
                pol_act  <= pol_sh;
            end
            pwm <= en ? ((cnt < duty_act) ^ pol_act) : pol_act;
        end
    end
endmodule

// File: rtl/pwm_multichannel.sv
// PWM bank: shared edge/center counter, boundary detect and shadowed period/mode.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = PWM_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load,
    input  logic [CNT_W-1:0]          period_in,
    input  logic [CHANNELS*CNT_W-1:0] duty_in,
    input  logic                      mode_in,
    input  logic [CHANNELS-1:0]       pol_in,
    output logic [CHANNELS-1:0]       pwm,
    output logic                      period_end,
    output logic                      pending
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             dir_down, dir_nxt;
    logic [CNT_W-1:0] period_sh, period_act;
    pwm_mode_e        mode_sh, mode_act;
    logic             boundary, apply;

    always_comb begin
        cnt_nxt = '0;
        dir_nxt = 1'b0;
        if (period_act == '0) begin
            cnt_nxt = '0;
        end else if (mode_act == PWM_EDGE) begin
            cnt_nxt = (cnt >= period_act) ? '0 : cnt + ONE;
        end else if (dir_down || cnt >= period_act) begin
            // keep counting down until the step that lands on 0
            cnt_nxt = cnt - ONE;
            dir_nxt = (cnt != ONE);
        end else begin
            cnt_nxt = cnt + ONE;
        end
    end

    assign boundary = en && (cnt_nxt == '0);
    assign apply    = pending && (!en || boundary);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            dir_down   <= 1'b0;
            period_sh  <= '0;
            period_act <= '0;
            mode_sh    <= PWM_EDGE;
            mode_act   <= PWM_EDGE;
            pending    <= 1'b0;
            period_end <= 1'b0;
        end else begin
            cnt        <= en ? cnt_nxt : '0;
            dir_down   <= en ? dir_nxt : 1'b0;
            period_end <= boundary;
            if (load) begin
                period_sh <= period_in;
                mode_sh   <= pwm_mode_e'(mode_in);
            end
            if (apply) begin
                period_act <= period_sh;
                mode_act   <= mode_sh;
            end
            pending <= load || (pending && !apply);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_compare_ch #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .load    (load),
            .apply   (apply),
            .cnt     (cnt),
            .duty_in (duty_in[i*CNT_W +: CNT_W]),
            .pol_in  (pol_in[i]),
            .pwm     (pwm[i])
        );
    end
endmodule

// File: tb/tb_pwm_multichannel.sv
// Random and directed stimulus against a phase-index reference model of the PWM bank.
module tb_pwm_multichannel;
    localparam int CH = 4;
    localparam int W  = 16;

    logic          clk = 1'b0;
    logic          rst, en, load, mode_in;
    logic [W-1:0]  period_in;
    logic [CH*W-1:0] duty_in;
    logic [CH-1:0] pol_in, pwm;
    logic          period_end, pending;

    always #5 clk = ~clk;

    pwm_multichannel #(.CHANNELS(CH), .CNT_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .load       (load),
        .period_in  (period_in),
        .duty_in    (duty_in),
        .mode_in    (mode_in),
        .pol_in     (pol_in),
        .pwm        (pwm),
        .period_end (period_end),
        .pending    (pending)
    );

    int errors = 0;
    int checks = 0;

    // reference model: position within the period, not a counter/direction pair
    int          m_k;
    int          a_per, s_per;
    bit          a_mode, s_mode;
    int          a_duty[CH], s_duty[CH];
    bit [CH-1:0] a_pol, s_pol;
    bit          m_pend, m_pe;
    bit [CH-1:0] m_pwm;

    function automatic int len_of(int p, bit c);
        if (p == 0) return 1;
        return c ? 2 * p : p + 1;
    endfunction

    function automatic int cnt_of(int k, int p, bit c);
        return (c && k > p) ? 2 * p - k : k;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        bit [CH-1:0] n_pwm;
        bit          n_pe, apply, bnd, r, e, l;
        int          n_k, c, L;
        int          in_duty[CH];
        int          in_per;
        bit          in_mode;
        bit [CH-1:0] in_pol;
        r = rst; e = en; l = load;
        in_per = int'(period_in); in_mode = mode_in; in_pol = pol_in;
        for (int i = 0; i < CH; i++) in_duty[i] = int'(duty_in[i*W +: W]);
        n_pwm = '0; n_pe = 0; apply = 0; n_k = 0;
        if (!r) begin
            L   = len_of(a_per, a_mode);
            bnd = e && (m_k == L - 1);
            c   = cnt_of(m_k, a_per, a_mode);
            for (int i = 0; i < CH; i++)
                n_pwm[i] = e ? ((c < a_duty[i]) ^ a_pol[i]) : a_pol[i];
            n_pe  = bnd;
            apply = m_pend && (!e || bnd);
            n_k   = (e && !bnd) ? m_k + 1 : 0;
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_k = 0; a_per = 0; s_per = 0; a_mode = 0; s_mode = 0;
            a_pol = '0; s_pol = '0; m_pend = 0; m_pe = 0; m_pwm = '0;
            for (int i = 0; i < CH; i++) begin a_duty[i] = 0; s_duty[i] = 0; end
        end else begin
            m_k = n_k; m_pwm = n_pwm; m_pe = n_pe;
            if (apply) begin
                a_per = s_per; a_mode = s_mode; a_pol = s_pol;
                for (int i = 0; i < CH; i++) a_duty[i] = s_duty[i];
            end
            if (l) begin
                s_per = in_per; s_mode = in_mode; s_pol = in_pol;
                for (int i = 0; i < CH; i++) s_duty[i] = in_duty[i];
            end
            m_pend = l || (m_pend && !apply);
        end
        chk("pwm", 32'(pwm), 32'(m_pwm));
        chk("period_end", 32'(period_end), 32'(m_pe));
        chk("pending", 32'(pending), 32'(m_pend));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_cfg(input int p, input bit c, input int d0, input int d1,
                           input int d2, input int d3, input bit [CH-1:0] pol);
        period_in = W'(p);
        mode_in   = c;
        duty_in   = {W'(d3), W'(d2), W'(d1), W'(d0)};
        pol_in    = pol;
    endtask

    task automatic do_load();
        load = 1'b1; tick(); load = 1'b0;
    endtask

    task automatic count(input int n, output int hi, output int pe);
        hi = 0; pe = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            hi += int'(pwm[0]);
            pe += int'(period_end);
        end
    endtask

    task automatic wait_pe();
        int n;
        n = 0;
        while (period_end !== 1'b1 && n < 300) begin tick(); n++; end
        if (period_end !== 1'b1) chk("pe_timeout", 0, 1);
    endtask

    int hi, pe, L;

    initial begin
        rst = 1; en = 0; load = 0;
        set_cfg(0, 0, 0, 0, 0, 0, '0);
        m_k = 0;
        ticks(2);
        chk("reset_pwm", 32'(pwm), 0);
        chk("reset_pending", 32'(pending), 0);
        rst = 0;

        // edge steady state
        set_cfg(9, 0, 3, 0, 10, 0, '0);
        do_load(); tick();
        en = 1; ticks(5);
        count(20, hi, pe);
        chk("edge_hi", hi, 6);
        chk("edge_pe", pe, 2);

        // center, then inverted polarity
        set_cfg(4, 1, 2, 0, 10, 0, '0);
        do_load(); ticks(20);
        count(16, hi, pe);
        chk("center_hi", hi, 6);
        chk("center_pe", pe, 2);
        set_cfg(4, 1, 2, 0, 10, 0, 4'b0001);
        do_load(); ticks(20);
        count(16, hi, pe);
        chk("center_pol_hi", hi, 10);

        // double buffering: mid-period duty 9 -> 5
        set_cfg(9, 0, 9, 0, 0, 0, '0);
        do_load(); ticks(25);
        wait_pe(); ticks(3);
        set_cfg(9, 0, 5, 0, 0, 0, '0);
        do_load();
        chk("db_pending", 32'(pending), 1);
        count(5, hi, pe);
        wait_pe();
        chk("db_pend_clear", 32'(pending), 0);
        count(10, hi, pe);
        chk("db_hi", hi, 5);

        // load A mid-period, load B on the boundary cycle
        ticks(3);
        set_cfg(9, 0, 2, 0, 0, 0, '0);
        do_load();
        L = len_of(a_per, a_mode);
        for (int i = 0; i < 30 && m_k != L - 1; i++) tick();
        set_cfg(9, 0, 7, 0, 0, 0, '0);
        do_load();
        chk("lob_pending", 32'(pending), 1);
        count(10, hi, pe);
        chk("lob_a_hi", hi, 2);
        wait_pe();
        count(10, hi, pe);
        chk("lob_b_hi", hi, 7);

        // enable low applies pending config immediately, outputs at idle
        set_cfg(9, 0, 3, 3, 3, 3, 4'b0101);
        do_load();
        en = 0; ticks(3);
        chk("idle_pwm", 32'(pwm), 32'h5);
        chk("idle_pending", 32'(pending), 0);
        en = 1; ticks(13);
        set_cfg(6, 1, 1, 2, 3, 4, 4'b1111);
        do_load(); ticks(2);
        rst = 1; tick(); rst = 0;
        chk("rst_pwm", 32'(pwm), 0);
        chk("rst_pending", 32'(pending), 0);

        // degenerate period 0
        set_cfg(0, 0, 1, 0, 0, 0, '0);
        do_load(); ticks(5);
        count(10, hi, pe);
        chk("p0_hi", hi, 10);
        chk("p0_pe", pe, 10);
        set_cfg(0, 1, 0, 0, 0, 0, '0);
        do_load(); ticks(5);
        count(10, hi, pe);
        chk("p0_d0_hi", hi, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int p;
            p = $urandom_range(0, 12);
            if ($urandom_range(0, 15) == 0) begin
                set_cfg(p, 1'($urandom_range(0, 1)),
                        $urandom_range(0, p + 2), $urandom_range(0, p + 2),
                        $urandom_range(0, p + 2), $urandom_range(0, p + 2),
                        4'($urandom_range(0, 15)));
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            en  = ($urandom_range(0, 39) != 0);
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 0; load = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pwm_multichannel.md
# pwm_multichannel

Parametrised multi-channel PWM generator. It replaces the single-channel fixed-frequency divider with a programmable period and a per-channel compare value. It supports edge- and center-aligned modes and per-channel output polarity. All configuration is double-buffered so updates take effect only at a period boundary, which keeps outputs glitch-free. It sits between the register/config logic and the output pins, one instance per PWM bank.

## Interface
- CHANNELS, 4, number of PWM outputs sharing one counter
- CNT_W, 16, counter, period and compare width in bits
- Clk  in  1  system clock
- Rst  in  1  synchronous, active-high reset
- En  in  1  run enable; low = counter held at 0, outputs at idle level
- Load  in  1  one-cycle strobe; captures all *_in inputs into shadow registers
- Period_in  in  CNT_W  last counter value of the up-count
- Duty_in  in  CHANNELS*CNT_W  compare values; channel i at [i*CNT_W +: CNT_W]
- Mode_in  in  1  0 = edge-aligned, 1 = center-aligned
- Pol_in  in  CHANNELS  per-channel invert; 1 = active-low output
- Pwm  out  CHANNELS  registered PWM outputs
- PeriodEnd  out  1  one-cycle pulse, registered, flags a period boundary
- Pending  out  1  shadow holds values not yet applied

## Operation
- **Reset:**
  - Counter 0, direction up.
  - Active and shadow registers: period 0, duties 0, mode edge, pol 0.
  - Pending 0, Pwm all 0, PeriodEnd 0.
- **Edge mode:**
  - Counter runs 0..Period, then wraps to 0.
  - Period length is Period+1 cycles.
- **Center mode:**
  - Counter runs 0 up to Period, then Period-1 down to 1, then 0.
  - Period length is 2*Period cycles.
  - Direction flips to down on the cycle where counter == Period.
- **Period==0 (either mode):** counter stays at 0 and every cycle is a boundary.
- **Boundary cycle:** the cycle whose next counter value is 0 (starts a new period) while En=1.
- **Compare:** raw[i] = (cnt < duty_act[i]); Pwm[i] <= raw[i] ^ pol_act[i].
  - duty 0 gives a constant inactive level.
  - duty > Period gives a constant active level.
  - Full-on at Period = 2^CNT_W-1 is unreachable; this is accepted.
- **Load:**
  - Shadow <= *_in and Pending <= 1.
  - A Load while Pending=1 overwrites the shadow; last write wins.
- **Update, with En=1:**
  - On a boundary cycle with Pending=1, active <= shadow and Pending <= 0.
  - The new values govern the next period, starting at cnt 0.
- **Load on a boundary cycle:**
  - The pre-Load shadow, if it was pending, is applied at this boundary.
  - The new shadow is stored and Pending stays 1 for the next boundary.
- **En=0:**
  - Counter <= 0, direction <= up.
  - Pwm[i] <= pol_act[i], the idle inactive level.
  - If Pending=1, active <= shadow immediately and Pending <= 0 (Load wins if asserted in the same cycle, as above).
  - No PeriodEnd is generated.
- **En rising:** the counter starts at 0 on the first enabled cycle.
- **PeriodEnd:** registered on the boundary cycle, so it is visible one cycle later, aligned with cnt == 0.

## Timing
- Single clock domain; all outputs are registered.
- Pwm latency is 1 cycle from the counter value to the output.
  - The first enabled cycle (cnt 0) appears on Pwm one cycle after En rises.
- Load to shadow: 1 cycle. Pending is high the cycle after Load.
- Load to active, with En=1: applied at the first boundary after the Load cycle.
  - Pwm reflects the new values from the second cycle of the new period (1-cycle output latency).
- Rst has priority over En and Load in every cycle.
- A reset mid-period returns to the reset state on the next edge; the shadow is lost.

## Structure
- Package pwm_pkg holds:
  - typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e
  - the default CNT_W constant
- Sub-module pwm_compare_ch is instantiated CHANNELS times in a generate loop. Each instance holds:
  - its shadow/active duty and polarity
  - the compare and output register, taking cnt and a shared apply strobe
- The top level holds:
  - the counter and direction
  - the boundary detect
  - the Pending flag and mode/period shadow

## Test plan
- **Edge, steady state:** Period=9, Duty0=3, Duty1=0, Duty2=10, Pol=0, En=1 -> Pwm0 high 3 / low 7 per 10 cycles; Pwm1 constant 0; Pwm2 constant 1; PeriodEnd every 10 cycles.
- **Center:** Period=4, Duty0=2 -> 8-cycle period; Pwm0 high 3 cycles centered on cnt 0 (2*Duty-1); Pol0=1 gives the complement.
- **Double-buffering:** mid-period Load of Duty0 9→5 -> current period unchanged, Pending=1; the next period shows 5 high cycles; Pending clears at the boundary.
- **Load on boundary:** Load A, then Load B exactly on the boundary cycle -> A is applied this period, B the next; Pending stays 1 across the boundary.
- **Enable/reset:** En=0 with Pol=4'b0101 -> Pwm=4'b0101, counter 0, a pending Load applied immediately; a Rst pulse mid-period -> all outputs 0 and Pending 0 next cycle.
- **Degenerate:** Period=0, Duty0=1 -> Pwm0 constant 1 and PeriodEnd high every cycle; Period=0, Duty0=0 -> Pwm0 constant 0.
